// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down counter arbiter slice.
package updown_ctrl_pkg;

    // Encoding of req_up: 1 asks for an increment, 0 for a decrement.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of a requester index / round-robin pointer for n requesters.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer and the last-grant index.
module rr_arbiter
    import updown_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic          found;
    logic [PW:0]   slot;

    // Walk the request vector from the pointer upward with wrap-around; first hit wins.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = {1'b0, ptr} + (PW+1)'(k);
            if (slot >= (PW+1)'(NREQ)) begin
                slot = slot - (PW+1)'(NREQ);
            end
            if (!found && req[slot[PW-1:0]]) begin
                found                = 1'b1;
                win_idx              = slot[PW-1:0];
                grant[slot[PW-1:0]]  = 1'b1;
            end
        end
    end

    // On a completed transfer, remember the winner and hand priority to its neighbour.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            grant_idx <= '0;
        end else if (advance && found) begin
            grant_idx <= win_idx;
            if (win_idx == PW'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= win_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_arbiter.sv
// Bounded up/down counter shared by NREQ requesters through a round-robin arbiter.
module updown_counter_arbiter
    import updown_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int LIMIT = 100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_up,
    output logic [NREQ-1:0]            req_ready,
    output logic [W-1:0]               count,
    output logic                       at_zero,
    output logic                       at_limit,
    output logic [ptr_width(NREQ)-1:0] grant_idx
);

    localparam int PW = ptr_width(NREQ);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("updown_counter_arbiter: NREQ must be in 2..16");
    end
    if (LIMIT <= 0 || 64'(LIMIT) >= (64'(1) << W)) begin : g_bad_limit
        $error("updown_counter_arbiter: LIMIT must satisfy 0 < LIMIT < 2**W");
    end

    logic [NREQ-1:0] legal;
    logic [NREQ-1:0] arb_req;
    logic            transfer;
    logic            win_dir;

    assign at_zero  = (count == '0);
    assign at_limit = (count == W'(LIMIT));

    // A request is legal only if its step keeps the count inside [0, LIMIT]; reset and clear mask everything.
    always_comb begin
        legal   = req_valid
                & ~(req_up  & {NREQ{at_limit}})
                & ~(~req_up & {NREQ{at_zero}});
        arb_req = (reset || clear) ? '0 : legal;
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (arb_req),
        .advance   (transfer),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // The grant is one-hot, so the winner's direction is the OR of its masked up bit.
    always_comb begin
        transfer = |(req_valid & req_ready);
        win_dir  = |(req_ready & req_up);
    end

    // Count register: reset and clear zero it, otherwise step by one on a transfer.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (transfer) begin
            if (win_dir == DIR_UP) begin
                count <= count + 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FORMAL
    a_count_range : assert property (@(posedge clock) count <= W'(LIMIT));
    a_grant_onehot : assert property (@(posedge clock) $onehot0(req_ready));
    a_count_step : assert property (@(posedge clock) disable iff (reset)
        !clear |=> (count == $past(count) || count == $past(count) + 1'b1 || count == $past(count) - 1'b1));
`endif

endmodule
